bfs_level_sched: RTL and testbench

- Level-synchronous BFS scheduler that sequences the 8-pipeline BFS datapath (bfs pipelines, sorter, update buffer) one level at a time.
- Clears vertex state, then streams the edge list once per level, tagging words with index and last flag.
- Waits for the datapath done, counts emitted updates, and advances current_level until a level produces no updates or MAX_LEVEL is reached.
- Sits between the edge-memory reader (valid/ready source) and the bfs datapath control/stream inputs.

---
 rtl/bfs_level_sched.sv | 195 +++++++++++++++++++
 tb/tb_bfs_level_sched.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfs_level_sched.sv
// Level-synchronous BFS scheduler: clears vertex state, then streams the edge list once per level until a level produces no updates or max_level is reached.
// Optional drain watchdog enabled by defining BFS_LEVEL_SCHED_TIMEOUT_EN.
module bfs_level_sched #(
    parameter int LEVEL_W     = 8,
    parameter int INIT_CYCLES = 16,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_edge_words,
    input  logic [LEVEL_W-1:0] max_level,
    input  logic [511:0]       src_word,
    input  logic               src_valid,
    output logic               src_ready,
    output logic [511:0]       word_in,
    output logic               word_in_valid,
    output logic [CNT_W-1:0]   word_in_th,
    output logic               last_input_in,
    output logic [1:0]         control,
    output logic [LEVEL_W-1:0] current_level,
    input  logic               dp_done,
    input  logic               dp_valid,
    output logic               busy,
    output logic               finished,
    output logic [LEVEL_W-1:0] levels_run,
    output logic               timeout_err
);

    // state   | meaning
    // IDLE    | waiting for start
    // INIT    | control=3, clearing vertex state for INIT_CYCLES cycles
    // SCAN    | streaming edge words of the current level
    // DRAIN   | waiting for the datapath to finish the level
    // CHECK   | decide next level or stop
    // DONE    | one-cycle finished pulse
    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_SCAN, S_DRAIN, S_CHECK, S_DONE
    } state_t;

    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state, state_nxt;
    logic [INIT_W-1:0]  init_cnt;
    logic [CNT_W-1:0]   words_q;
    logic [CNT_W-1:0]   idx;
    logic [CNT_W-1:0]   upd_cnt;
    logic [LEVEL_W-1:0] max_q;
    logic               xfer, last_xfer, init_tc, drain_tc, check_stop;

    assign xfer       = (state == S_SCAN) && src_valid;
    assign last_xfer  = xfer && (idx == words_q - CNT_ONE);
    assign init_tc    = (init_cnt == '0);
    assign check_stop = (upd_cnt == '0) || (current_level == max_q);

`ifdef BFS_LEVEL_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] drain_cnt;

    // Reloaded outside DRAIN so it always starts fresh on DRAIN entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_cnt <= '0;
        end else if (state != S_DRAIN) begin
            drain_cnt <= TO_W'(TIMEOUT - 1);
        end else if (drain_cnt != '0) begin
            drain_cnt <= drain_cnt - TO_W'(1);
        end
    end

    assign drain_tc = (state == S_DRAIN) && (drain_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_err <= 1'b0;
        end else if (state == S_IDLE && start) begin
            timeout_err <= 1'b0;
        end else if (state == S_DRAIN && !dp_done && drain_tc) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign drain_tc    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        control   = 2'd0;
        src_ready = 1'b0;
        busy      = 1'b1;
        finished  = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = (num_edge_words == '0) ? S_DONE : S_INIT;
            end
            S_INIT: begin
                control = 2'd3;
                if (init_tc) state_nxt = S_SCAN;
            end
            S_SCAN: begin
                control   = 2'd1;
                src_ready = 1'b1;
                if (last_xfer) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                control = 2'd2;
                if (dp_done)       state_nxt = S_CHECK;
                else if (drain_tc) state_nxt = S_DONE;
            end
            S_CHECK: begin
                control   = 2'd2;
                state_nxt = check_stop ? S_DONE : S_SCAN;
            end
            S_DONE: begin
                finished  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_cnt <= '0;
        end else if (state != S_INIT) begin
            init_cnt <= INIT_W'(INIT_CYCLES - 1);
        end else if (!init_tc) begin
            init_cnt <= init_cnt - INIT_W'(1);
        end
    end

    // Index restarts every time SCAN is entered, so it wraps per level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else if (state != S_SCAN) begin
            idx <= '0;
        end else if (xfer) begin
            idx <= idx + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_in       <= '0;
            word_in_valid <= 1'b0;
            word_in_th    <= '0;
            last_input_in <= 1'b0;
        end else begin
            word_in_valid <= xfer;
            last_input_in <= last_xfer;
            if (xfer) begin
                word_in    <= src_word;
                word_in_th <= idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_cnt <= '0;
        end else if ((state == S_IDLE && start) || state == S_CHECK) begin
            upd_cnt <= '0;
        end else if ((state == S_SCAN || state == S_DRAIN) && dp_valid && upd_cnt != '1) begin
            upd_cnt <= upd_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            words_q       <= '0;
            max_q         <= '0;
            current_level <= '0;
            levels_run    <= '0;
        end else if (state == S_IDLE && start) begin
            words_q       <= num_edge_words;
            max_q         <= max_level;
            current_level <= '0;
            levels_run    <= '0;
        end else if (state == S_CHECK) begin
            levels_run <= levels_run + LEVEL_W'(1);
            if (!check_stop) current_level <= current_level + LEVEL_W'(1);
        end
    end

endmodule

// File: tb/tb_bfs_level_sched.sv
// Directed bench for bfs_level_sched: reset, multi-level runs, gaps, max_level stop, zero words,
// same-cycle dp_valid/dp_done, and the watchdog when BFS_LEVEL_SCHED_TIMEOUT_EN is defined.
module tb_bfs_level_sched;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  num_edge_words = '0;
    logic [7:0]   max_level = '0;
    logic [511:0] src_word = '0;
    logic         src_valid = 1'b0;
    logic         src_ready;
    logic [511:0] word_in;
    logic         word_in_valid;
    logic [31:0]  word_in_th;
    logic         last_input_in;
    logic [1:0]   control;
    logic [7:0]   current_level;
    logic         dp_done = 1'b0;
    logic         dp_valid = 1'b0;
    logic         busy;
    logic         finished;
    logic [7:0]   levels_run;
    logic         timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    int   q_th[$];
    bit   q_last[$];
    int   q_lvl[$];
    int   init_seen, drain_seen, fin_cnt, fin_cycle, word_bad;
    bit   timed_out;
    logic ready_after_last;

    bfs_level_sched #(
        .LEVEL_W(8), .INIT_CYCLES(16), .CNT_W(32), .TIMEOUT(32)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .num_edge_words(num_edge_words), .max_level(max_level),
        .src_word(src_word), .src_valid(src_valid), .src_ready(src_ready),
        .word_in(word_in), .word_in_valid(word_in_valid), .word_in_th(word_in_th),
        .last_input_in(last_input_in), .control(control), .current_level(current_level),
        .dp_done(dp_done), .dp_valid(dp_valid), .busy(busy), .finished(finished),
        .levels_run(levels_run), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one run and records what the DUT emits; the scenario tasks judge the records.
    task automatic run_bfs(input int n, input int maxl, input int upd0, input int upd_rest,
                           input bit gaps, input bit merge, input bit noise, input bit no_done);
        int cyc = 0, dcnt = 0, lvl = 0, xfer = 0, scan_seen = 0, nupd;
        bit done_sent = 0, ph = 0, last_pending = 0;
        logic [511:0] exp_q[$];
        logic [511:0] exp_w;
        q_th.delete(); q_last.delete(); q_lvl.delete();
        init_seen = 0; drain_seen = 0; fin_cnt = 0; fin_cycle = -1; word_bad = 0;
        timed_out = 0; ready_after_last = 1'bx;
        num_edge_words = n;
        max_level = 8'(maxl);
        src_valid = 1'b0; dp_valid = 1'b0; dp_done = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        if (noise) num_edge_words = '0;
        while (fin_cnt == 0 && cyc < 600) begin
            if (control == 2'd3) init_seen++;
            if (control == 2'd2) drain_seen++;
            if (word_in_valid) begin
                q_th.push_back(int'(word_in_th));
                q_last.push_back(last_input_in);
                q_lvl.push_back(int'(current_level));
                if (exp_q.size() == 0) word_bad++;
                else begin
                    exp_w = exp_q.pop_front();
                    if (word_in !== exp_w) word_bad++;
                end
            end
            if (last_pending) begin
                ready_after_last = src_ready;
                last_pending = 0;
            end
            if (finished) begin
                fin_cnt++;
                fin_cycle = cyc;
            end
            start = 1'b0; dp_valid = 1'b0; dp_done = 1'b0;
            for (int i = 0; i < 16; i++) src_word[i*32 +: 32] = $urandom;
            if (control == 2'd1) begin
                if (done_sent) begin
                    done_sent = 0;
                    dcnt = 0;
                end
                src_valid = gaps ? !ph : 1'b1;
                ph = !ph;
                if (noise && scan_seen == 0) dp_done = 1'b1;
                scan_seen++;
            end else begin
                src_valid = !gaps;
            end
            if (src_ready && src_valid) begin
                exp_q.push_back(src_word);
                xfer++;
                if (n > 0 && xfer % n == 0) last_pending = 1;
            end
            if (control == 2'd2 && !done_sent && !no_done) begin
                nupd = (lvl == 0) ? upd0 : upd_rest;
                if (merge && nupd > 0) begin
                    dp_valid = 1'b1;
                    dp_done  = 1'b1;
                end else if (dcnt < nupd) dp_valid = 1'b1;
                else dp_done = 1'b1;
                if (dp_done) begin
                    done_sent = 1;
                    lvl++;
                end
                dcnt++;
            end
            if (noise && control == 2'd3 && init_seen == 5) start = 1'b1;
            tick();
            cyc++;
        end
        if (fin_cnt == 0) timed_out = 1;
        start = 1'b0; dp_valid = 1'b0; dp_done = 1'b0; src_valid = 1'b0;
    endtask

    task automatic test_reset();
        int fin = 0;
        #3;
        n_cmp++;
        if ({busy, finished, src_ready, word_in_valid, last_input_in, timeout_err} !== 6'b0 ||
            control !== 2'd0 || current_level !== 8'd0 || levels_run !== 8'd0 ||
            word_in_th !== 32'd0 || word_in !== 512'd0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b ctl=%0d lvl=%0d run=%0d th=%0d, required all 0",
                     busy, control, current_level, levels_run, word_in_th);
        end
        tick(); tick();
        rst = 1'b1;
        tick();
        num_edge_words = 32'd8; max_level = 8'd3; src_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 50 && control != 2'd1; k++) tick();
        n_cmp++;
        if (control !== 2'd1) begin
            n_bad++;
            $display("FAIL reset_reach_scan: control=%0d required 1", control);
        end
        tick(); tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({busy, finished, src_ready, word_in_valid, last_input_in, timeout_err} !== 6'b0 ||
            control !== 2'd0 || word_in_th !== 32'd0 || word_in !== 512'd0) begin
            n_bad++;
            $display("FAIL reset_mid_scan: busy=%b rdy=%b wv=%b ctl=%0d th=%0d, required all 0",
                     busy, src_ready, word_in_valid, control, word_in_th);
        end
        tick(); tick();
        rst = 1'b1;
        src_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (finished) fin++;
            tick();
        end
        n_cmp++;
        if (fin != 0 || busy !== 1'b0 || src_ready !== 1'b0 || control !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_after: finished_pulses=%0d busy=%b rdy=%b ctl=%0d, required 0 0 0 0",
                     fin, busy, src_ready, control);
        end
    endtask

    task automatic test_basic_levels();
        int exp_th[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
        int exp_lvl[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        run_bfs(4, 10, 3, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (timed_out || fin_cnt != 1) begin
            n_bad++;
            $display("FAIL basic_finished: pulses=%0d timed_out=%0d, required 1 0", fin_cnt, timed_out);
        end
        n_cmp++;
        if (init_seen != 16) begin
            n_bad++;
            $display("FAIL basic_init_cycles: got %0d required 16", init_seen);
        end
        n_cmp++;
        if (q_th.size() != 8) begin
            n_bad++;
            $display("FAIL basic_word_count: got %0d required 8", q_th.size());
        end
        for (int i = 0; i < 8 && i < q_th.size(); i++) begin
            n_cmp++;
            if (q_th[i] != exp_th[i] || q_lvl[i] != exp_lvl[i] || q_last[i] != (exp_th[i] == 3)) begin
                n_bad++;
                $display("FAIL basic_word%0d: th=%0d lvl=%0d last=%0d, required %0d %0d %0d",
                         i, q_th[i], q_lvl[i], q_last[i], exp_th[i], exp_lvl[i], exp_th[i] == 3);
            end
        end
        n_cmp++;
        if (word_bad != 0) begin
            n_bad++;
            $display("FAIL basic_word_data: bad words=%0d required 0", word_bad);
        end
        n_cmp++;
        if (levels_run !== 8'd2 || current_level !== 8'd1) begin
            n_bad++;
            $display("FAIL basic_levels: levels_run=%0d current_level=%0d, required 2 1",
                     levels_run, current_level);
        end
        tick();
        n_cmp++;
        if (finished !== 1'b0 || busy !== 1'b0 || control !== 2'd0) begin
            n_bad++;
            $display("FAIL basic_idle_after: finished=%b busy=%b ctl=%0d, required 0 0 0",
                     finished, busy, control);
        end
    endtask

    task automatic test_gaps();
        run_bfs(3, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (q_th.size() != 3) begin
            n_bad++;
            $display("FAIL gaps_word_count: got %0d required 3", q_th.size());
        end
        for (int i = 0; i < 3 && i < q_th.size(); i++) begin
            n_cmp++;
            if (q_th[i] != i || q_last[i] != (i == 2)) begin
                n_bad++;
                $display("FAIL gaps_word%0d: th=%0d last=%0d, required %0d %0d",
                         i, q_th[i], q_last[i], i, i == 2);
            end
        end
        n_cmp++;
        if (ready_after_last !== 1'b0) begin
            n_bad++;
            $display("FAIL gaps_ready_drop: src_ready=%b after last word, required 0", ready_after_last);
        end
        n_cmp++;
        if (word_bad != 0 || fin_cnt != 1 || levels_run !== 8'd1) begin
            n_bad++;
            $display("FAIL gaps_result: bad=%0d pulses=%0d levels_run=%0d, required 0 1 1",
                     word_bad, fin_cnt, levels_run);
        end
    endtask

    task automatic test_max_level();
        run_bfs(2, 1, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (timed_out || fin_cnt != 1) begin
            n_bad++;
            $display("FAIL maxlvl_finished: pulses=%0d timed_out=%0d, required 1 0", fin_cnt, timed_out);
        end
        n_cmp++;
        if (levels_run !== 8'd2 || current_level !== 8'd1 || q_th.size() != 4) begin
            n_bad++;
            $display("FAIL maxlvl_levels: levels_run=%0d current_level=%0d words=%0d, required 2 1 4",
                     levels_run, current_level, q_th.size());
        end
    endtask

    task automatic test_same_cycle_update();
        run_bfs(1, 5, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (fin_cnt != 1 || levels_run !== 8'd2 || current_level !== 8'd1) begin
            n_bad++;
            $display("FAIL merge_update: pulses=%0d levels_run=%0d current_level=%0d, required 1 2 1",
                     fin_cnt, levels_run, current_level);
        end
    endtask

    task automatic test_zero_words();
        run_bfs(0, 4, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (fin_cycle != 1) begin
            n_bad++;
            $display("FAIL zero_latency: finished at cycle %0d required 1", fin_cycle);
        end
        n_cmp++;
        if (levels_run !== 8'd0 || q_th.size() != 0 || init_seen != 0) begin
            n_bad++;
            $display("FAIL zero_result: levels_run=%0d words=%0d init=%0d, required 0 0 0",
                     levels_run, q_th.size(), init_seen);
        end
        tick();
        n_cmp++;
        if (finished !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_idle: finished=%b busy=%b, required 0 0", finished, busy);
        end
    endtask

`ifdef BFS_LEVEL_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        run_bfs(2, 3, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (fin_cnt != 1 || timeout_err !== 1'b1 || levels_run !== 8'd0) begin
            n_bad++;
            $display("FAIL timeout_flag: pulses=%0d timeout_err=%b levels_run=%0d, required 1 1 0",
                     fin_cnt, timeout_err, levels_run);
        end
        n_cmp++;
        if (drain_seen != 32) begin
            n_bad++;
            $display("FAIL timeout_drain_cycles: got %0d required 32", drain_seen);
        end
        tick(); tick();
        n_cmp++;
        if (timeout_err !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_sticky: timeout_err=%b required 1", timeout_err);
        end
        num_edge_words = 32'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (timeout_err !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_clear: timeout_err=%b required 0", timeout_err);
        end
        tick(); tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_levels();
        test_gaps();
        test_max_level();
        test_same_cycle_update();
        test_zero_words();
`ifdef BFS_LEVEL_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
